// File: rtl/score_counter.sv
// Button-driven bounded up/down counter for a two-digit display.
// Raw switches pass through synchronisers, debouncers, edge detection and hold-to-repeat before stepping the count.
module score_counter #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000,
  parameter int MAX_COUNT      = 99,
  parameter bit WRAP           = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_Up,
  input  logic       i_Switch_Down,
  input  logic       i_Switch_Clear,
  output logic [6:0] o_Counter,
  output logic       o_Step,
  output logic       o_Wrap
);

  localparam int DB_W   = $clog2(DEBOUNCE_LIMIT + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
  localparam logic [6:0]      MAX_VAL    = 7'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  // Bit order everywhere: 0 = up, 1 = down, 2 = clear.
  logic [2:0] raw;
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] level;
  logic [2:0] level_d;
  logic [2:0] rise;
  logic [1:0] step_req;
  logic       clear_req;
  logic [6:0] count;

  assign raw       = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};
  assign rise      = level & ~level_d;
  assign clear_req = rise[2];

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_a  <= '0;
      sync_b  <= '0;
      level_d <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_debounce
    logic [DB_W-1:0] timer;
    logic            lvl;

    assign level[g] = lvl;

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        timer <= '0;
        lvl   <= 1'b0;
      end else if (sync_b[g] == lvl) begin
        timer <= '0;
      end else if (timer == DB_LAST) begin
        timer <= '0;
        lvl   <= ~lvl;
      end else begin
        timer <= timer + DB_W'(1);
      end
    end
  end

  // Step requests are combinational so the count moves on the edge right after the debounced press.
  for (genvar g = 0; g < 2; g++) begin : g_repeat
    rep_state_t      state;
    logic [RP_W-1:0] timer;

    assign step_req[g] = ((state == IDLE) && rise[g]) ||
                         ((state == HOLD) && level[g] && (timer == DELAY_LAST)) ||
                         ((state == REPEAT) && level[g] && (timer == RATE_LAST));

    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            timer <= '0;
            if (rise[g]) state <= HOLD;
          end
          HOLD: begin
            if (!level[g]) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == DELAY_LAST) begin
              state <= REPEAT;
              timer <= '0;
            end else begin
              timer <= timer + RP_W'(1);
            end
          end
          REPEAT: begin
            if (!level[g]) begin
              state <= IDLE;
              timer <= '0;
            end else if (timer == RATE_LAST) begin
              timer <= '0;
            end else begin
              timer <= timer + RP_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  // Clear beats everything; simultaneous up and down cancel out.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      count  <= '0;
      o_Step <= 1'b0;
      o_Wrap <= 1'b0;
    end else begin
      o_Step <= 1'b0;
      o_Wrap <= 1'b0;
      if (clear_req) begin
        count  <= '0;
        o_Step <= (count != 7'd0);
      end else if (step_req[0] && !step_req[1]) begin
        if (count >= MAX_VAL) begin
          if (WRAP) begin
            count  <= '0;
            o_Step <= 1'b1;
            o_Wrap <= 1'b1;
          end
        end else begin
          count  <= count + 7'd1;
          o_Step <= 1'b1;
        end
      end else if (step_req[1] && !step_req[0]) begin
        if (count == 7'd0) begin
          if (WRAP) begin
            count  <= MAX_VAL;
            o_Step <= 1'b1;
            o_Wrap <= 1'b1;
          end
        end else begin
          count  <= count - 7'd1;
          o_Step <= 1'b1;
        end
      end
    end
  end

  assign o_Counter = count;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: a wrapping and a saturating instance share one stimulus stream
// and are compared every cycle against a timing-rule model plus directed checkpoints.
module tb_score_counter;

  localparam int DL = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int MC = 99;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       sw_up;
  logic       sw_down;
  logic       sw_clear;
  logic [6:0] cnt_w;
  logic       step_w;
  logic       wrap_w;
  logic [6:0] cnt_s;
  logic       step_s;
  logic       wrap_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_counter #(
    .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .MAX_COUNT(MC), .WRAP(1'b1)
  ) dut_wrap (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Switch_Up(sw_up), .i_Switch_Down(sw_down),
    .i_Switch_Clear(sw_clear), .o_Counter(cnt_w), .o_Step(step_w), .o_Wrap(wrap_w)
  );

  score_counter #(
    .DEBOUNCE_LIMIT(DL), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .MAX_COUNT(MC), .WRAP(1'b0)
  ) dut_sat (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Switch_Up(sw_up), .i_Switch_Down(sw_down),
    .i_Switch_Clear(sw_clear), .o_Counter(cnt_s), .o_Step(step_s), .o_Wrap(wrap_s)
  );

  // Reference: a level flips once the last DL synchronised samples all disagree with it;
  // a held button steps at hold time 0, RD, RD+RR, RD+2RR, ...
  bit          q1 [3];
  bit          q2 [3];
  bit [DL-1:0] win [3];
  int          filled [3];
  bit          lvl [3];
  bit          lvl_prev [3];
  int          held [3];
  int          m_cnt [2];
  bit          m_step [2];
  bit          m_wrap [2];

  always @(posedge clk) begin : ref_model
    bit raw [3];
    bit req [3];
    int nv;
    raw[0] = sw_up;
    raw[1] = sw_down;
    raw[2] = sw_clear;
    if (!rst_l) begin
      for (int i = 0; i < 3; i++) begin
        q1[i] = 0; q2[i] = 0; win[i] = '0; filled[i] = 0;
        lvl[i] = 0; lvl_prev[i] = 0; held[i] = 0;
      end
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_step[w] = 0; m_wrap[w] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++)
        req[i] = lvl[i] && (held[i] == 0 || (held[i] >= RD && (held[i] - RD) % RR == 0));
      req[2] = lvl[2] && !lvl_prev[2];
      for (int w = 0; w < 2; w++) begin
        m_wrap[w] = 0;
        nv = m_cnt[w];
        if (req[2]) nv = 0;
        else if (req[0] && !req[1]) nv = m_cnt[w] + 1;
        else if (req[1] && !req[0]) nv = m_cnt[w] - 1;
        if (nv > MC) begin
          nv = (w == 0) ? 0 : MC;
          m_wrap[w] = (w == 0);
        end else if (nv < 0) begin
          nv = (w == 0) ? MC : 0;
          m_wrap[w] = (w == 0);
        end
        m_step[w] = (nv != m_cnt[w]);
        m_cnt[w] = nv;
      end
      for (int i = 0; i < 3; i++) begin
        lvl_prev[i] = lvl[i];
        held[i] = lvl[i] ? held[i] + 1 : 0;
        win[i] = {win[i][DL-2:0], q2[i]};
        if (filled[i] < DL) filled[i]++;
        if (filled[i] == DL && win[i] == {DL{!lvl[i]}}) lvl[i] = !lvl[i];
        q2[i] = q1[i];
        q1[i] = raw[i];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_model();
    check_output("cnt_wrap",  32'(cnt_w),  32'(m_cnt[0]));
    check_output("step_wrap", 32'(step_w), 32'(m_step[0]));
    check_output("wrap_wrap", 32'(wrap_w), 32'(m_wrap[0]));
    check_output("cnt_sat",   32'(cnt_s),  32'(m_cnt[1]));
    check_output("step_sat",  32'(step_s), 32'(m_step[1]));
    check_output("wrap_sat",  32'(wrap_s), 32'(m_wrap[1]));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_model();
    end
  endtask

  task automatic apply_stimulus(input bit up, input bit down, input bit clear, input int hold, input int gap);
    sw_up = up; sw_down = down; sw_clear = clear;
    tick(hold);
    sw_up = 0; sw_down = 0; sw_clear = 0;
    tick(gap);
  endtask

  initial begin
    rst_l = 0; sw_up = 0; sw_down = 0; sw_clear = 0;
    tick(3);
    check_output("reset_cnt", 32'(cnt_w), 0);
    check_output("reset_step", 32'(step_w), 0);
    rst_l = 1;
    tick(2);

    // Single press: count moves exactly 7 cycles after the raw edge.
    sw_up = 1;
    tick(6);
    check_output("press_early", 32'(cnt_w), 0);
    tick(1);
    check_output("press_cnt", 32'(cnt_w), 1);
    check_output("press_step", 32'(step_w), 1);
    check_output("press_wrap", 32'(wrap_w), 0);
    tick(3);
    sw_up = 0;
    tick(20);
    check_output("press_hold", 32'(cnt_w), 1);
    apply_stimulus(0, 0, 1, 8, 10);
    check_output("clear_cnt", 32'(cnt_w), 0);

    // Short glitches never pass the debouncer.
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0, 0, 3, 3);
    tick(10);
    check_output("glitch_cnt", 32'(cnt_w), 0);

    // Auto-repeat from 5.
    for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 8, 10);
    check_output("five_cnt", 32'(cnt_w), 5);
    sw_up = 1;
    tick(7);
    check_output("rep_first", 32'(cnt_w), 6);
    tick(19);
    check_output("rep_delay_early", 32'(cnt_w), 6);
    tick(1);
    check_output("rep_delay", 32'(cnt_w), 7);
    tick(5);
    check_output("rep_rate", 32'(cnt_w), 8);
    tick(28);
    sw_up = 0;
    tick(30);
    check_output("rep_final", 32'(cnt_w), 14);

    // Bounds: wrap vs saturate.
    apply_stimulus(0, 0, 1, 8, 10);
    apply_stimulus(0, 1, 0, 8, 10);
    check_output("down_wrap", 32'(cnt_w), MC);
    check_output("down_sat", 32'(cnt_s), 0);
    apply_stimulus(1, 0, 0, 8, 10);
    check_output("up_wrap", 32'(cnt_w), 0);
    check_output("up_sat_start", 32'(cnt_s), 1);
    apply_stimulus(1, 0, 0, 520, 20);
    check_output("sat_top", 32'(cnt_s), MC);
    apply_stimulus(1, 0, 0, 8, 10);
    check_output("sat_hold", 32'(cnt_s), MC);

    // Coincident requests at 42.
    apply_stimulus(0, 0, 1, 8, 10);
    apply_stimulus(1, 0, 0, 224, 20);
    check_output("reach_42", 32'(cnt_w), 42);
    apply_stimulus(1, 1, 0, 8, 10);
    check_output("updown_42", 32'(cnt_w), 42);
    check_output("updown_42_sat", 32'(cnt_s), 42);
    sw_clear = 1; sw_up = 1;
    tick(7);
    check_output("clear_up_cnt", 32'(cnt_w), 0);
    check_output("clear_up_step", 32'(step_w), 1);
    tick(1);
    sw_clear = 0; sw_up = 0;
    tick(10);

    // Reset while held in repeat.
    apply_stimulus(0, 0, 1, 8, 10);
    sw_up = 1;
    tick(169);
    check_output("repeat_30", 32'(cnt_w), 30);
    rst_l = 0;
    tick(1);
    rst_l = 1;
    check_output("midreset_cnt", 32'(cnt_w), 0);
    tick(6);
    check_output("midreset_early", 32'(cnt_w), 0);
    tick(1);
    check_output("midreset_step", 32'(cnt_w), 1);
    sw_up = 0;
    tick(30);

    // Random presses, glitches and occasional resets.
    for (int it = 0; it < 250; it++) begin
      sw_up    = 1'($urandom_range(0, 1));
      sw_down  = ($urandom_range(0, 3) == 0);
      sw_clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        rst_l = 0;
        tick(1);
        rst_l = 1;
      end
      tick($urandom_range(1, 35));
    end
    sw_up = 0; sw_down = 0; sw_clear = 0;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Produces the 7-bit value (0..MAX_COUNT) that feeds the two-digit seven-segment decoder.
- Takes the raw board switches (up, down, clear) and conditions them: 2-FF synchronisation, then debounce, then rising-edge detection, then hold-to-auto-repeat.
- Maintains a bounded up/down count, which is registered and drives the decoder's counter input directly.

Parameters:
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles before a debounced level changes (10 ms at 25 MHz).
- REPEAT_DELAY, 12500000: cycles a button must stay held after its first step before auto-repeat starts (0.5 s).
- REPEAT_RATE, 2500000: cycles between auto-repeat steps while held (0.1 s).
- MAX_COUNT, 99: upper bound of the count. Must be ≤ 99 and ≥ 1.
- WRAP, 1: 1 = wrap at the bounds; 0 = saturate at the bounds.

Ports:
- i_Clk, input, 1: system clock; all logic on the rising edge.
- i_Rst_L, input, 1: synchronous active-low reset.
- i_Switch_Up, input, 1: raw switch, active-high when pressed, asynchronous.
- i_Switch_Down, input, 1: raw switch, active-high, asynchronous.
- i_Switch_Clear, input, 1: raw switch, active-high, asynchronous.
- o_Counter, output, 7: current count, 0..MAX_COUNT, registered.
- o_Step, output, 1: one-cycle pulse on every cycle o_Counter changes value.
- o_Wrap, output, 1: one-cycle pulse when a wrap (MAX_COUNT→0 or 0→MAX_COUNT) occurs.

Behaviour:
- Reset (i_Rst_L=0 at a clock edge):
  - o_Counter=0, o_Step=0, o_Wrap=0.
  - Sync flops=0; debounced levels=0 (released); debounce and repeat timers=0; all button FSMs to IDLE.
  - Reset mid-press: the button is treated as released. A still-held button must re-debounce from 0 before any step is taken.
- Synchroniser: two flops per input. The debouncer sees each input 2 cycles late.
- Debounce (per button):
  - A timer counts while the synchronised input differs from the debounced level.
  - Any cycle where they agree clears the timer to 0.
  - When the timer reaches DEBOUNCE_LIMIT-1, the debounced level toggles and the timer clears.
  - Glitches shorter than DEBOUNCE_LIMIT cycles never change the level.
- Up/Down FSM (independent per button), states IDLE, HOLD, REPEAT:
  - IDLE: on a debounced rising edge, issue 1 step request and go to HOLD with the repeat timer at 0.
  - HOLD: repeat timer increments. When it reaches REPEAT_DELAY-1, issue a step request, clear the timer, go to REPEAT.
  - REPEAT: when the timer reaches REPEAT_RATE-1, issue a step request and clear the timer.
  - HOLD or REPEAT: a debounced low returns the FSM to IDLE immediately; no step is issued that cycle.
- Clear: a debounced rising edge only; no auto-repeat. Sets the count to 0.
- Count update happens in the cycle after the step request is generated. Latency from a raw press edge to the o_Counter change is exactly 2 + DEBOUNCE_LIMIT + 1 cycles.
- Priority when requests coincide in the same cycle:
  1. Clear wins.
  2. Up and Down together: no change, and no o_Step.
  3. Otherwise a single ±1.
- Arithmetic:
  - Up at MAX_COUNT: becomes 0 with o_Wrap=1 if WRAP=1; holds MAX_COUNT if WRAP=0.
  - Down at 0: becomes MAX_COUNT with o_Wrap=1 if WRAP=1; holds 0 if WRAP=0.
  - Saturated holds and Clear at 0 produce no o_Step (the value did not change).
- Invariant: o_Counter never exceeds MAX_COUNT, under any input sequence.
- o_Step and o_Wrap are registered and asserted in the same cycle as the new o_Counter value.

Test Plan:
Bench parameters: DEBOUNCE_LIMIT=4, REPEAT_DELAY=20, REPEAT_RATE=5, MAX_COUNT=99.
- Reset, then Up held 10 cycles → o_Counter goes 0→1 exactly 7 cycles after the press edge, with a single o_Step pulse and o_Wrap=0.
- Up pulses of 3 cycles, separated by 3 cycles low, repeated 10 times → o_Counter stays 0 and o_Step never asserts.
- Up held 60 cycles from count 5 → first step to 6 after 7 cycles, 7 after 20 more, then +1 every 5 cycles. After release, no further steps.
- WRAP=1: at 99 press Up → 0 with o_Wrap=1. At 0 press Down → 99 with o_Wrap=1. Repeat with WRAP=0 → count holds at 99 / 0, and o_Step and o_Wrap both stay 0.
- Count 42, Up and Down debounced on the same cycle → stays 42, no o_Step. Then Clear and Up together → 0 with o_Step=1.
- Up held into REPEAT at count 30, then i_Rst_L low 1 cycle while still held → o_Counter=0 next cycle, and the next step to 1 occurs only after a full 2+4+1 re-debounce.
